// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the EX-stage ALU.
//   - ALU_OP field encodings coming from the main decoder
//   - internal 4-bit operation codes produced by alu_op_decode
//   - FSM state encodings used by alu_exec_unit
package alu_pkg;

  // ALU_OP field from the main decoder
  localparam logic [1:0] OP_RTYPE = 2'b00;
  localparam logic [1:0] OP_BR    = 2'b01;
  localparam logic [1:0] OP_MEM   = 2'b10;

  // Number of defined R-type function codes (0..NUM_OPS-1)
  localparam int NUM_OPS = 10;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_MULT = 4'd2,
    ALU_SLL  = 4'd3,
    ALU_SRL  = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_SLT  = 4'd7,
    ALU_XOR  = 4'd8,
    ALU_NOT  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational decode of {ALU_OP, ALU_OP_CODE} to an internal op.
// Ports:
//   alu_op       in   2      ALU_OP field (mem / branch / R-type)
//   alu_op_code  in   OPC_W  R-type function code
//   op           out  4      decoded operation (alu_op_e)
//   illegal      out  1      request has no defined op; op falls back to ADD
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [1:0]       alu_op,
  input  logic [OPC_W-1:0] alu_op_code,
  output alu_op_e          op,
  output logic             illegal
);

  always_comb begin
    op      = ALU_ADD;
    illegal = 1'b0;
    case (alu_op)
      OP_MEM: op = ALU_ADD;
      OP_BR:  op = ALU_SUB;
      OP_RTYPE: begin
        // Function codes map one-to-one onto alu_op_e for the defined range.
        if (32'(alu_op_code) < NUM_OPS) begin
          op = alu_op_e'(4'(alu_op_code));
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ops return a registered result one cycle after accept; MULT runs
// an iterative shift-add over WIDTH cycles.
// Ports:
//   CLK, RESET               clock, synchronous active-high reset
//   IN_VALID / IN_READY      request handshake
//   ALU_OP, ALU_OP_CODE      operation select
//   SRC_A, SRC_B             operands (SRC_B low bits are the shift amount)
//   OUT_VALID / OUT_READY    result handshake
//   RESULT, ZERO, ILLEGAL    registered result and flags
//   BUSY                     multiply iteration in progress
//
// state   | meaning
// --------+--------------------------------------------------------
// ST_IDLE | no result held, ready for a request
// ST_MUL  | shift-add multiply iterating, no request accepted
// ST_DONE | result held on RESULT/flags until OUT_READY
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPC_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [1:0]       ALU_OP,
  input  logic [OPC_W-1:0] ALU_OP_CODE,
  input  logic [WIDTH-1:0] SRC_A,
  input  logic [WIDTH-1:0] SRC_B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             ILLEGAL,
  output logic             BUSY
);

  localparam int SH_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SH_W-1:0]  cnt_q, cnt_d;

  alu_op_e          dec_op;
  logic             dec_illegal;
  logic             is_mul;
  logic             accept;
  logic [SH_W-1:0]  sh_amt;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_step;

  alu_op_decode #(.OPC_W(OPC_W)) u_decode (
    .alu_op      (ALU_OP),
    .alu_op_code (ALU_OP_CODE),
    .op          (dec_op),
    .illegal     (dec_illegal)
  );

  assign is_mul = (dec_op == ALU_MULT);
  assign sh_amt = SRC_B[SH_W-1:0];

  // Single-cycle datapath
  always_comb begin
    alu_res = SRC_A + SRC_B;
    case (dec_op)
      ALU_ADD: alu_res = SRC_A + SRC_B;
      ALU_SUB: alu_res = SRC_A - SRC_B;
      ALU_SLL: alu_res = SRC_A << sh_amt;
      ALU_SRL: alu_res = SRC_A >> sh_amt;
      ALU_AND: alu_res = SRC_A & SRC_B;
      ALU_OR:  alu_res = SRC_A | SRC_B;
      ALU_XOR: alu_res = SRC_A ^ SRC_B;
      ALU_NOT: alu_res = ~SRC_A;
      ALU_SLT: begin
        alu_res    = '0;
        alu_res[0] = ($signed(SRC_A) < $signed(SRC_B));
      end
      default: alu_res = SRC_A + SRC_B;
    endcase
  end

  // Multiplier keeps A pre-shifted and B shifted down, so bit 0 of B and the
  // current A together equal B[count] and A<<count of the textbook form.
  assign acc_step = acc_q + (mul_b_q[0] ? mul_a_q : '0);

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = is_mul ? ST_MUL : ST_DONE;
      end
      ST_MUL: begin
        if (cnt_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (OUT_READY) begin
          if (accept) state_d = is_mul ? ST_MUL : ST_DONE;
          else        state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    IN_READY  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && OUT_READY);
    OUT_VALID = (state_q == ST_DONE);
    BUSY      = (state_q == ST_MUL);
    accept    = IN_VALID && IN_READY;
  end

  // Datapath registers: next values
  always_comb begin
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;

    if (accept) begin
      if (is_mul) begin
        mul_a_d = SRC_A;
        mul_b_d = SRC_B;
        acc_d   = '0;
        // Down-counter: terminal count 0 marks the last of WIDTH iterations.
        cnt_d   = SH_W'(WIDTH - 1);
      end else begin
        result_d  = alu_res;
        zero_d    = (alu_res == '0);
        illegal_d = dec_illegal;
      end
    end else if (state_q == ST_MUL) begin
      acc_d   = acc_step;
      mul_a_d = mul_a_q << 1;
      mul_b_d = mul_b_q >> 1;
      if (cnt_q == '0) begin
        result_d  = acc_step;
        zero_d    = (acc_step == '0);
        illegal_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
    end
  end

  assign RESULT  = result_q;
  assign ZERO    = zero_q;
  assign ILLEGAL = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IN_VALID;
  logic        IN_READY;
  logic [1:0]  ALU_OP;
  logic [3:0]  ALU_OP_CODE;
  logic [15:0] SRC_A;
  logic [15:0] SRC_B;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [15:0] RESULT;
  logic        ZERO;
  logic        ILLEGAL;
  logic        BUSY;

  alu_exec_unit #(.WIDTH(16), .OPC_W(4)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .ALU_OP      (ALU_OP),
    .ALU_OP_CODE (ALU_OP_CODE),
    .SRC_A       (SRC_A),
    .SRC_B       (SRC_B),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .RESULT      (RESULT),
    .ZERO        (ZERO),
    .ILLEGAL     (ILLEGAL),
    .BUSY        (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [3:0]  code;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        z;
    logic        ill;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(string nm, logic [1:0] op, logic [3:0] code,
                              logic [15:0] a, logic [15:0] b, logic [15:0] res,
                              logic z, logic ill);
    vec_t v;
    v.name = nm; v.op = op; v.code = code; v.a = a; v.b = b;
    v.res = res; v.z = z; v.ill = ill;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change at negedge+1; the monitor samples at negedge+3.
  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic issue(vec_t v);
    int guard = 0;
    ALU_OP = v.op; ALU_OP_CODE = v.code; SRC_A = v.a; SRC_B = v.b;
    IN_VALID = 1'b1;
    #1;
    while (!IN_READY && guard < 100) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (!IN_READY) begin
      n_err++;
      $display("FAIL %s_accept: IN_READY never rose", v.name);
    end else begin
      sb.push_back(v);
    end
    tick();
    IN_VALID = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 60) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results outstanding", sb.size());
      sb.delete();
    end
  endtask

  // Scoreboard monitor: pops on every completed output handshake.
  always @(negedge CLK) begin
    vec_t e;
    #3;
    if (!RESET && OUT_VALID && OUT_READY) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got %0h expected none", RESULT);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_result"}, 32'(RESULT), 32'(e.res));
        chk({e.name, "_zero"}, 32'(ZERO), 32'(e.z));
        chk({e.name, "_illegal"}, 32'(ILLEGAL), 32'(e.ill));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int busy_cnt;

    RESET = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
    ALU_OP = 2'b00; ALU_OP_CODE = 4'd0; SRC_A = '0; SRC_B = '0;

    tbl.push_back(mk("add_ovf",   2'b00, 4'd0,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0));
    tbl.push_back(mk("br_sub_eq", 2'b01, 4'd5,  16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0));
    tbl.push_back(mk("slt_neg",   2'b00, 4'd7,  16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0));
    tbl.push_back(mk("slt_false", 2'b00, 4'd7,  16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0));
    tbl.push_back(mk("ill_c12",   2'b00, 4'd12, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b1));
    tbl.push_back(mk("ill_c15",   2'b00, 4'd15, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b1));
    tbl.push_back(mk("ill_op11",  2'b11, 4'd0,  16'h0005, 16'h0006, 16'h000B, 1'b0, 1'b1));
    tbl.push_back(mk("sll_hi_b",  2'b00, 4'd3,  16'h0001, 16'h0013, 16'h0008, 1'b0, 1'b0));
    tbl.push_back(mk("srl",       2'b00, 4'd4,  16'h8000, 16'h0004, 16'h0800, 1'b0, 1'b0));
    tbl.push_back(mk("and",       2'b00, 4'd5,  16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0));
    tbl.push_back(mk("or",        2'b00, 4'd6,  16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0, 1'b0));
    tbl.push_back(mk("xor_zero",  2'b00, 4'd8,  16'hAAAA, 16'hAAAA, 16'h0000, 1'b1, 1'b0));
    tbl.push_back(mk("not",       2'b00, 4'd9,  16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b0));
    tbl.push_back(mk("mem_add",   2'b10, 4'd3,  16'hFFFF, 16'h0002, 16'h0001, 1'b0, 1'b0));
    tbl.push_back(mk("sub_wrap",  2'b00, 4'd1,  16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0));
    tbl.push_back(mk("mult",      2'b00, 4'd2,  16'h0123, 16'h0045, 16'h4E6F, 1'b0, 1'b0));
    tbl.push_back(mk("mult_max",  2'b00, 4'd2,  16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0));
    tbl.push_back(mk("mult_zero", 2'b00, 4'd2,  16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0));

    tick(); tick();
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_result",    32'(RESULT),    32'd0);
    chk("rst_zero",      32'(ZERO),      32'd0);
    chk("rst_illegal",   32'(ILLEGAL),   32'd0);
    chk("rst_busy",      32'(BUSY),      32'd0);
    RESET = 1'b0;
    tick();
    chk("rst_in_ready",  32'(IN_READY),  32'd1);

    // Table sweep, one op at a time
    foreach (tbl[i]) begin
      issue(tbl[i]);
      drain();
    end

    // Single-cycle latency: result visible one cycle after accept
    issue(mk("lat1", 2'b00, 4'd0, 16'h0010, 16'h0020, 16'h0030, 1'b0, 1'b0));
    chk("lat1_valid", 32'(OUT_VALID), 32'd1);
    drain();

    // MULT timing with operand churn, then stall in DONE
    OUT_READY = 1'b0;
    issue(mk("mult_stall", 2'b00, 4'd2, 16'h0123, 16'h0045, 16'h4E6F, 1'b0, 1'b0));
    SRC_A = 16'hFFFF; SRC_B = 16'hFFFF; ALU_OP_CODE = 4'd0;
    chk("mul_in_ready", 32'(IN_READY), 32'd0);
    cyc = 1; busy_cnt = 0;
    while (!OUT_VALID && cyc < 40) begin
      if (BUSY) busy_cnt++;
      tick();
      cyc++;
    end
    chk("mul_busy_cycles", 32'(busy_cnt), 32'd16);
    chk("mul_valid_cycle", 32'(cyc), 32'd17);
    chk("mul_busy_done",   32'(BUSY), 32'd0);
    for (int k = 0; k < 5; k++) begin
      chk("stall_result",   32'(RESULT),    32'h4E6F);
      chk("stall_in_ready", 32'(IN_READY),  32'd0);
      chk("stall_valid",    32'(OUT_VALID), 32'd1);
      tick();
    end

    // Back-to-back: ADD accepted in the same cycle OUT_READY rises
    OUT_READY = 1'b1;
    issue(mk("b2b_add", 2'b00, 4'd0, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0));
    chk("b2b_valid",  32'(OUT_VALID), 32'd1);
    chk("b2b_result", 32'(RESULT),    32'h0005);
    drain();

    // Back-to-back into MULT: OUT_VALID drops while multiplying
    OUT_READY = 1'b0;
    issue(mk("b2m_add", 2'b00, 4'd6, 16'h0100, 16'h0001, 16'h0101, 1'b0, 1'b0));
    OUT_READY = 1'b1;
    issue(mk("b2m_mul", 2'b00, 4'd2, 16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0));
    chk("b2m_valid_drop", 32'(OUT_VALID), 32'd0);
    chk("b2m_busy",       32'(BUSY),      32'd1);
    drain();

    // Reset in the middle of a multiply
    issue(mk("mul_rst", 2'b00, 4'd2, 16'h0123, 16'h0045, 16'h4E6F, 1'b0, 1'b0));
    for (int k = 1; k < 8; k++) tick();
    chk("pre_rst_busy", 32'(BUSY), 32'd1);
    RESET = 1'b1;
    tick();
    sb.delete();
    chk("rst_mid_valid",    32'(OUT_VALID), 32'd0);
    chk("rst_mid_busy",     32'(BUSY),      32'd0);
    chk("rst_mid_in_ready", 32'(IN_READY),  32'd1);
    chk("rst_mid_result",   32'(RESULT),    32'd0);
    RESET = 1'b0;
    tick();
    issue(mk("post_rst", 2'b00, 4'd5, 16'h0F0F, 16'h00FF, 16'h000F, 1'b0, 1'b0));
    drain();

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
